// File: rtl/ariane_soc_pkg.sv
// rtl/ariane_soc_pkg.sv - shared arbiter state type and key-select helpers
package ariane_soc_pkg;

    // Width of the key-bank select carried to the AES core.
    localparam int AES_KSEL_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

    // Only banks 0..2 exist; encoding 3 aliases onto bank 2.
    function automatic logic [AES_KSEL_W-1:0] map_ksel(input logic [AES_KSEL_W-1:0] ksel);
        return (ksel == 2'd3) ? 2'd2 : ksel;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last grant
// Ports:
//   req_i  : request vector
//   last_i : index of the previously served requester
//   gnt_o  : one-hot winner (zero when no request)
//   idx_o  : winner index
//   any_o  : at least one request present
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_i,
    input  logic [$clog2(N_REQ)-1:0] last_i,
    output logic [N_REQ-1:0]         gnt_o,
    output logic [$clog2(N_REQ)-1:0] idx_o,
    output logic                     any_o
);

    always_comb begin : pick
        int  j;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        // Walk last+1, last+2, ... wrapping, so the last winner has lowest priority.
        for (int i = 1; i <= N_REQ; i++) begin
            j = (int'(last_i) + i) % N_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = ($clog2(N_REQ))'(j);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/aes_job_arbiter.sv
// rtl/aes_job_arbiter.sv - shares one AES core among N_REQ requesters, one job at a time
// Ports:
//   clk_i, rst_i                 : clock, async active-high reset
//   req_valid_i/req_ready_o      : job handshake; req_pt_i/req_ksel_i per-requester payload
//   resp_valid_o/resp_ready_i    : one-hot result handshake; resp_ct_o/resp_err_o shared result
//   core_start_o/core_pt_o/core_ksel_o : job issue to the core
//   core_ct_i/core_valid_i       : core result and level-held done flag
//   lock_i                       : blocks new grants only
//   busy_o/grant_id_o            : job in flight and its owner
module aes_job_arbiter
    import ariane_soc_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         req_valid_i,
    output logic [N_REQ-1:0]         req_ready_o,
    input  logic [N_REQ*128-1:0]     req_pt_i,
    input  logic [N_REQ*2-1:0]       req_ksel_i,
    output logic [N_REQ-1:0]         resp_valid_o,
    input  logic [N_REQ-1:0]         resp_ready_i,
    output logic [127:0]             resp_ct_o,
    output logic                     resp_err_o,
    output logic                     core_start_o,
    output logic [127:0]             core_pt_o,
    output logic [AES_KSEL_W-1:0]    core_ksel_o,
    input  logic [127:0]             core_ct_i,
    input  logic                     core_valid_i,
    input  logic                     lock_i,
    output logic                     busy_o,
    output logic [$clog2(N_REQ)-1:0] grant_id_o
);

    localparam int IDW   = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);

    arb_state_t            r_state;
    logic [IDW-1:0]        r_last;
    logic [IDW-1:0]        r_grant;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_armed;
    logic                  r_start;
    logic                  r_busy;
    logic                  r_err;
    logic [127:0]          r_ct;
    logic [127:0]          r_pt;
    logic [AES_KSEL_W-1:0] r_ksel;
    logic [N_REQ-1:0]      r_resp_valid;

    logic [N_REQ-1:0]      w_gnt;
    logic [IDW-1:0]        w_idx;
    logic                  w_any;
    logic                  w_take;
    logic [N_REQ-1:0]      w_grant_oh;

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req_i  (req_valid_i),
        .last_i (r_last),
        .gnt_o  (w_gnt),
        .idx_o  (w_idx),
        .any_o  (w_any)
    );

    // The accept pulse must be visible in the same IDLE cycle the request is seen,
    // so it is decoded from state; reset gating keeps it low while rst_i is high.
    assign w_take      = (r_state == ST_IDLE) && !lock_i && w_any && !rst_i;
    assign req_ready_o = w_take ? w_gnt : '0;
    assign w_grant_oh  = N_REQ'(1) << r_grant;

    assign resp_valid_o = r_resp_valid;
    assign resp_ct_o    = r_ct;
    assign resp_err_o   = r_err;
    assign core_start_o = r_start;
    assign core_pt_o    = r_pt;
    assign core_ksel_o  = r_ksel;
    assign busy_o       = r_busy;
    assign grant_id_o   = r_grant;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_last       <= IDW'(N_REQ - 1);
            r_grant      <= '0;
            r_cnt        <= '0;
            r_armed      <= 1'b0;
            r_start      <= 1'b0;
            r_busy       <= 1'b0;
            r_err        <= 1'b0;
            r_ct         <= '0;
            r_pt         <= '0;
            r_ksel       <= '0;
            r_resp_valid <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_take) begin
                        r_pt    <= req_pt_i[128*int'(w_idx) +: 128];
                        r_ksel  <= map_ksel(req_ksel_i[2*int'(w_idx) +: 2]);
                        r_grant <= w_idx;
                        r_start <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_start <= 1'b0;
                    r_cnt   <= '0;
                    r_armed <= 1'b0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // A done level left over from the previous job is ignored until
                    // the core has been seen low at least once for this job.
                    if (r_armed && core_valid_i) begin
                        r_ct         <= core_ct_i;
                        r_err        <= 1'b0;
                        r_resp_valid <= w_grant_oh;
                        r_state      <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_ct         <= '0;
                        r_err        <= 1'b1;
                        r_resp_valid <= w_grant_oh;
                        r_state      <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (!core_valid_i) begin
                            r_armed <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    if (resp_ready_i[r_grant]) begin
                        r_resp_valid <= '0;
                        r_err        <= 1'b0;
                        r_busy       <= 1'b0;
                        r_last       <= r_grant;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_job_arbiter.sv
// tb/tb_aes_job_arbiter.sv - randomized self-checking bench for aes_job_arbiter
module tb_aes_job_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready, resp_valid, resp_ready;
    logic [N*128-1:0]  req_pt;
    logic [N*2-1:0]    req_ksel;
    logic [127:0]      resp_ct, core_pt, core_ct;
    logic              resp_err, core_start, core_valid, lock, busy;
    logic [1:0]        core_ksel;
    logic [1:0]        grant_id;

    always #5 clk = ~clk;

    aes_job_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_pt_i     (req_pt),
        .req_ksel_i   (req_ksel),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_ct_o    (resp_ct),
        .resp_err_o   (resp_err),
        .core_start_o (core_start),
        .core_pt_o    (core_pt),
        .core_ksel_o  (core_ksel),
        .core_ct_i    (core_ct),
        .core_valid_i (core_valid),
        .lock_i       (lock),
        .busy_o       (busy),
        .grant_id_o   (grant_id)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int m_last = N - 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Round-robin reference: first requester after the last served one, wrapping.
    function automatic int pick(input logic [N-1:0] mask, input int last);
        for (int i = 1; i <= N; i++) begin
            if (mask[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic randomize_reqs();
        for (int i = 0; i < N; i++) begin
            req_pt[128*i +: 128] = rand128();
            req_ksel[2*i +: 2]   = 2'($urandom_range(0, 3));
        end
    endtask

    // One complete job. Core done waveform in WAIT cycle k: high for k<s (stale),
    // low for s<=k<s+z, high afterwards.
    task automatic run_job(input logic [N-1:0] mask, input int s, input int z,
                           input int bp, input bit lock_idle, output int w);
        logic [127:0] exp_pt, exp_ct;
        logic [1:0]   ks, exp_ks;
        bit           v[TO];
        logic [127:0] cts[TO];
        bit           armed, exp_err;
        int           kd, kfin;
        logic [N-1:0] w_oh;

        w      = pick(mask, m_last);
        w_oh   = N'(1) << w;
        exp_pt = req_pt[128*w +: 128];
        ks     = req_ksel[2*w +: 2];
        exp_ks = (ks == 2'd3) ? 2'd2 : ks;

        if (lock_idle) begin
            lock      = 1'b1;
            req_valid = mask;
            for (int c = 0; c < 3; c++) begin
                #1;
                chk("ready_while_locked", req_ready, '0);
                chk("busy_while_locked", busy, 1'b0);
                @(negedge clk);
            end
        end

        lock      = 1'b0;
        req_valid = mask;
        #1;
        chk("grant_onehot", req_ready, w_oh);
        chk("busy_at_grant", busy, 1'b0);

        @(negedge clk);
        chk("start_pulse", core_start, 1'b1);
        chk("core_pt", core_pt, exp_pt);
        chk("core_ksel", core_ksel, exp_ks);
        chk("grant_id", grant_id, 128'(w));
        chk("busy_issue", busy, 1'b1);
        chk("no_ready_issue", req_ready, '0);

        for (int k = 0; k < TO; k++) begin
            v[k]   = (k < s) ? 1'b1 : ((k < s + z) ? 1'b0 : 1'b1);
            cts[k] = rand128();
        end
        armed = 1'b0;
        kd    = -1;
        for (int k = 0; k < TO; k++) begin
            if (armed && v[k]) begin
                kd = k;
                break;
            end
            if (!v[k]) armed = 1'b1;
        end
        exp_err = (kd < 0);
        exp_ct  = exp_err ? 128'd0 : cts[kd];
        kfin    = exp_err ? TO - 1 : kd;

        for (int k = 0; k <= kfin; k++) begin
            @(negedge clk);
            chk("no_resp_in_wait", resp_valid, '0);
            chk("no_restart_in_wait", core_start, 1'b0);
            chk("busy_wait", busy, 1'b1);
            chk("no_ready_busy", req_ready, '0);
            core_valid = v[k];
            core_ct    = cts[k];
            lock       = 1'($urandom_range(0, 1));
        end

        @(negedge clk);
        core_ct = rand128();
        chk("resp_valid", resp_valid, w_oh);
        chk("resp_ct", resp_ct, exp_ct);
        chk("resp_err", resp_err, exp_err);
        chk("busy_resp", busy, 1'b1);

        for (int c = 0; c < bp; c++) begin
            resp_ready = N'($urandom) & ~w_oh;
            lock       = 1'b1;
            @(negedge clk);
            core_ct = rand128();
            chk("resp_held_valid", resp_valid, w_oh);
            chk("resp_held_ct", resp_ct, exp_ct);
            chk("resp_held_err", resp_err, exp_err);
            chk("no_ready_resp", req_ready, '0);
        end

        resp_ready = w_oh | N'($urandom);
        @(negedge clk);
        chk("resp_dropped", resp_valid, '0);
        chk("idle_not_busy", busy, 1'b0);
        m_last     = w;
        resp_ready = '0;
        req_valid  = '0;
        lock       = 1'b0;
    endtask

    int w;
    int fair_exp[4] = '{1, 2, 3, 0};

    initial begin
        rst        = 1'b1;
        req_valid  = 4'hF;
        resp_ready = '0;
        req_pt     = '0;
        req_ksel   = '0;
        core_ct    = '0;
        core_valid = 1'b0;
        lock       = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, '0);
        chk("rst_resp_valid", resp_valid, '0);
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_ct", resp_ct, '0);
        chk("rst_core_pt", core_pt, '0);
        chk("rst_core_ksel", core_ksel, '0);
        chk("rst_grant_id", grant_id, '0);
        rst       = 1'b0;
        req_valid = '0;
        @(negedge clk);

        // Single directed job: done 12 cycles after start.
        randomize_reqs();
        req_pt[127:0] = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        req_ksel[1:0] = 2'd1;
        run_job(4'b0001, 0, 11, 0, 1'b0, w);
        chk("single_grant", 128'(w), 128'd0);

        // Fairness with all four requesting.
        for (int i = 0; i < 4; i++) begin
            randomize_reqs();
            run_job(4'hF, 0, 3, 0, 1'b0, w);
            chk("fair_order", 128'(w), 128'(fair_exp[i]));
        end

        // Stale done level carried over from the previous job.
        randomize_reqs();
        run_job(4'hF, 3, 2, 0, 1'b0, w);

        // Core never completes.
        randomize_reqs();
        core_valid = 1'b0;
        run_job(4'b0100, 0, 40, 0, 1'b0, w);

        // Backpressure with lock held, then locked idle before next grant.
        randomize_reqs();
        run_job(4'b1010, 0, 5, 5, 1'b0, w);
        randomize_reqs();
        run_job(4'hF, 1, 4, 0, 1'b1, w);

        for (int j = 0; j < 30; j++) begin
            randomize_reqs();
            run_job(N'($urandom_range(1, 15)),
                    ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                    $urandom_range(0, 18), $urandom_range(0, 4),
                    ($urandom_range(0, 3) == 0), w);
        end

        // Reset in the middle of WAIT.
        randomize_reqs();
        req_valid = 4'hF;
        @(negedge clk);
        @(negedge clk);
        core_valid = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_req_ready", req_ready, '0);
        chk("midrst_resp_valid", resp_valid, '0);
        chk("midrst_core_start", core_start, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_core_pt", core_pt, '0);
        chk("midrst_core_ksel", core_ksel, '0);
        chk("midrst_grant_id", grant_id, '0);
        chk("midrst_resp_err", resp_err, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = '0;
        m_last    = N - 1;
        @(negedge clk);
        chk("post_rst_no_resp", resp_valid, '0);
        randomize_reqs();
        run_job(4'hF, 0, 2, 0, 1'b0, w);
        chk("post_rst_grant", 128'(w), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
